alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameter: DATA_WIDTH, default 32 (taken from shared package `defines`), operand/result width.
REQ-002 The design SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk_i  input  1  clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  synchronous active-high reset.
REQ-005 ALUSel_i  input  alu_sel_e (4 bits)  operation select.
REQ-006 alu_operand1_i  input  DATA_WIDTH  operand A (rs1 or PC).
REQ-007 alu_operand2_i  input  DATA_WIDTH  operand B (rs2 or immediate).
REQ-008 alu_result_o  output  DATA_WIDTH  registered result.
REQ-009 alu_zeroFlag_o  output  1  registered flag, 1 when the registered result is all zeros.

Function
REQ-010 Latency SHALL be exactly 1 cycle: inputs sampled at rising edge N appear on outputs after edge N; no handshake, one new operation accepted every cycle.
REQ-011 ADD: A+B; SUB: A-B; both wrap modulo 2^DATA_WIDTH with no overflow indication.
REQ-012 AND, OR, XOR: bitwise A op B.
REQ-013 SLL, SRL, SRA: shift A by B[4:0] only; upper bits of B ignored; SRA replicates A[31].
REQ-014 SLT: 1 if signed(A) < signed(B), else 0; SLTU: same, unsigned; result zero-extended to DATA_WIDTH.
REQ-015 PASS_B: result = B (LUI path); A ignored.
REQ-016 alu_zeroFlag_o SHALL equal (result == 0) for the same registered operation, for every operation.
REQ-017 Reserved/unused ALUSel_i encodings SHALL produce result 0, zero flag 1.
REQ-018 Shift amount 0 SHALL return A unchanged; shift by 31 SHALL be supported for all shift types.

Reset
REQ-019 While rst_i is high at a rising edge, alu_result_o SHALL become 0 and alu_zeroFlag_o 1, overriding any operation.
REQ-020 Reset asserted mid-stream SHALL discard the operation sampled on that edge; the first valid result appears one cycle after the first edge with rst_i low.

Configuration
REQ-021 Macro ALU_MUL_EN: when defined, MUL (low 32 bits of A*B), MULH (high 32, signed×signed), MULHSU (high 32, signed A × unsigned B), MULHU (high 32, unsigned×unsigned) SHALL be implemented with the same 1-cycle latency.
REQ-022 Without ALU_MUL_EN, the four multiply encodings SHALL behave as reserved (REQ-017) and no multiplier logic SHALL be synthesized.

Structure
REQ-023 Package `defines` SHALL hold DATA_WIDTH and enum alu_sel_e: ALU_ADD=0, ALU_SUB=1, ALU_SLL=2, ALU_SLT=3, ALU_SLTU=4, ALU_XOR=5, ALU_SRL=6, ALU_SRA=7, ALU_OR=8, ALU_AND=9, ALU_PASS_B=10, ALU_MUL=11, ALU_MULH=12, ALU_MULHSU=13, ALU_MULHU=14; 15 reserved.
REQ-024 The design SHALL consist of a combinational compute block plus an output register stage; a sub-module alu_mul (combinational 33x33 signed multiplier) SHALL be instantiated only under ALU_MUL_EN.

Verification
REQ-025 ADD 5,10 -> result 15, zero 0; SUB 10,10 -> result 0, zero 1; each checked one cycle after apply.
REQ-026 AND 3,1 -> 1; XOR 4,3 -> 7; OR 4,5 -> 5; PASS_B 10,3 -> 3; all zero 0.
REQ-027 SLL 4,1 -> 8; SRL 4,2 -> 1; SRA 10,2 -> 2; SRA -8,2 -> -2 (0xFFFFFFFE); SLL 1,0x21 -> 2 (only B[4:0] used).
REQ-028 SLT -20,10 -> 1, zero 0; SLT 10,-20 -> 0, zero 1; SLTU 3,5 -> 1; SLTU 5,3 -> 0, zero 1; SLTU 0xFFFFFFFF,1 -> 0.
REQ-029 Reset: drive ADD 5,10, assert rst_i on the same edge -> result 0, zero 1; deassert -> next op result after one cycle.
REQ-030 With ALU_MUL_EN: MULH 0x80000000,0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF,0xFFFFFFFF -> 0xFFFFFFFE; without it, MUL 3,4 -> 0, zero 1.

Source files
------------

// File: rtl/defines.sv
// Shared ALU definitions: the datapath width and the operation-select encoding.
package defines;

    localparam int DATA_WIDTH = 32;

    // Encoding 15 is reserved. Encodings 11-14 are also treated as reserved when ALU_MUL_EN is not defined.
    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10,
        ALU_MUL    = 4'd11,
        ALU_MULH   = 4'd12,
        ALU_MULHSU = 4'd13,
        ALU_MULHU  = 4'd14
    } alu_sel_e;

endpackage

// File: rtl/alu_mul.sv
// Combinational signed multiplier for (WIDTH+1)-bit operands.
// The caller's choice of the extra top bit selects signed or unsigned treatment of each operand.
module alu_mul #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]     a_i,
    input  logic [WIDTH:0]     b_i,
    output logic [2*WIDTH-1:0] product_o
);

    // The full (2*WIDTH+2)-bit product is never needed.
    // Sign-extending each operand to 2*WIDTH bits gives the exact low 2*WIDTH bits of the product.
    assign product_o = (2*WIDTH)'($signed(a_i)) * (2*WIDTH)'($signed(b_i));

endmodule

// File: rtl/alu.sv
// ALU with a combinational compute stage and a registered result and zero flag; latency is one cycle.
// Define ALU_MUL_EN to add the MUL, MULH, MULHSU and MULHU operations.
module alu
    import defines::*;
#(
    parameter int DATA_WIDTH = defines::DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  alu_sel_e              ALUSel_i,
    input  logic [DATA_WIDTH-1:0] alu_operand1_i,
    input  logic [DATA_WIDTH-1:0] alu_operand2_i,
    output logic [DATA_WIDTH-1:0] alu_result_o,
    output logic                  alu_zeroFlag_o
);

    // There is no valid/ready handshake. A new operation is sampled on every rising edge.
    // Its result is visible after that same edge.
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [4:0]            shamt;
    logic [DATA_WIDTH-1:0] result_d;

    assign op_a  = alu_operand1_i;
    assign op_b  = alu_operand2_i;
    assign shamt = op_b[4:0];

`ifdef ALU_MUL_EN
    logic                    mul_a_sign;
    logic                    mul_b_sign;
    logic [2*DATA_WIDTH-1:0] product;

    // A single signed multiplier serves all four operations.
    // Zero-extending an operand gives the unsigned variants.
    always_comb begin
        mul_a_sign = (ALUSel_i != ALU_MULHU) && op_a[DATA_WIDTH-1];
        mul_b_sign = ((ALUSel_i == ALU_MULH) || (ALUSel_i == ALU_MUL)) && op_b[DATA_WIDTH-1];
    end

    alu_mul #(
        .WIDTH(DATA_WIDTH)
    ) u_alu_mul (
        .a_i      ({mul_a_sign, op_a}),
        .b_i      ({mul_b_sign, op_b}),
        .product_o(product)
    );
`endif

    always_comb begin
        result_d = '0;
        case (ALUSel_i)
            ALU_ADD:    result_d = op_a + op_b;
            ALU_SUB:    result_d = op_a - op_b;
            ALU_SLL:    result_d = op_a << shamt;
            ALU_SLT:    result_d = DATA_WIDTH'($signed(op_a) < $signed(op_b));
            ALU_SLTU:   result_d = DATA_WIDTH'(op_a < op_b);
            ALU_XOR:    result_d = op_a ^ op_b;
            ALU_SRL:    result_d = op_a >> shamt;
            ALU_SRA:    result_d = $unsigned($signed(op_a) >>> shamt);
            ALU_OR:     result_d = op_a | op_b;
            ALU_AND:    result_d = op_a & op_b;
            ALU_PASS_B: result_d = op_b;
`ifdef ALU_MUL_EN
            ALU_MUL:    result_d = product[DATA_WIDTH-1:0];
            ALU_MULH,
            ALU_MULHSU,
            ALU_MULHU:  result_d = product[2*DATA_WIDTH-1:DATA_WIDTH];
`endif
            default:    result_d = '0;
        endcase
    end

    // The zero flag is registered next to the result so both always describe the same operation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alu_result_o   <= '0;
            alu_zeroFlag_o <= 1'b1;
        end else begin
            alu_result_o   <= result_d;
            alu_zeroFlag_o <= (result_d == '0);
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed testbench for alu.
// Each step applies one operation and checks the registered result and zero flag one cycle later.
module tb_alu;
    import defines::*;

    logic        clk;
    logic        rst;
    alu_sel_e    sel;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] result;
    logic        zero;

    int n_checks = 0;
    int n_errors = 0;

    alu dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .ALUSel_i      (sel),
        .alu_operand1_i(op1),
        .alu_operand2_i(op2),
        .alu_result_o  (result),
        .alu_zeroFlag_o(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] exp_res, input logic exp_zero);
        n_checks++;
        assert (result === exp_res) else begin
            n_errors++;
            $error("FAIL %s result: observed %h expected %h", tag, result, exp_res);
        end
        n_checks++;
        assert (zero === exp_zero) else begin
            n_errors++;
            $error("FAIL %s zero: observed %b expected %b", tag, zero, exp_zero);
        end
    endtask

    // Drive the inputs at the falling edge, let one rising edge register them, then sample 1 ns later.
    task automatic step(input string tag, input alu_sel_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input logic exp_zero);
        @(negedge clk);
        sel = op;
        op1 = a;
        op2 = b;
        @(posedge clk);
        #1;
        check(tag, exp_res, exp_zero);
    endtask

    initial begin
        rst = 1'b1;
        sel = ALU_ADD;
        op1 = 32'd0;
        op2 = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 32'd0, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        step("add_5_10",    ALU_ADD,    32'd5,          32'd10,         32'd15,         1'b0);
        step("sub_10_10",   ALU_SUB,    32'd10,         32'd10,         32'd0,          1'b1);
        step("add_wrap",    ALU_ADD,    32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1);
        step("sub_wrap",    ALU_SUB,    32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0);
        step("and_3_1",     ALU_AND,    32'd3,          32'd1,          32'd1,          1'b0);
        step("xor_4_3",     ALU_XOR,    32'd4,          32'd3,          32'd7,          1'b0);
        step("or_4_5",      ALU_OR,     32'd4,          32'd5,          32'd5,          1'b0);
        step("pass_b",      ALU_PASS_B, 32'd10,         32'd3,          32'd3,          1'b0);
        step("sll_4_1",     ALU_SLL,    32'd4,          32'd1,          32'd8,          1'b0);
        step("srl_4_2",     ALU_SRL,    32'd4,          32'd2,          32'd1,          1'b0);
        step("sra_10_2",    ALU_SRA,    32'd10,         32'd2,          32'd2,          1'b0);
        step("sra_m8_2",    ALU_SRA,    32'hFFFF_FFF8,  32'd2,          32'hFFFF_FFFE,  1'b0);
        step("sll_b_mask",  ALU_SLL,    32'd1,          32'h21,         32'd2,          1'b0);
        step("sll_0",       ALU_SLL,    32'hA5A5_0001,  32'd0,          32'hA5A5_0001,  1'b0);
        step("srl_0",       ALU_SRL,    32'h8000_0003,  32'h20,         32'h8000_0003,  1'b0);
        step("sra_0",       ALU_SRA,    32'h8000_0003,  32'd0,          32'h8000_0003,  1'b0);
        step("sll_31",      ALU_SLL,    32'd3,          32'd31,         32'h8000_0000,  1'b0);
        step("srl_31",      ALU_SRL,    32'h8000_0000,  32'd31,         32'd1,          1'b0);
        step("sra_31",      ALU_SRA,    32'h8000_0000,  32'd31,         32'hFFFF_FFFF,  1'b0);
        step("slt_m20_10",  ALU_SLT,    32'hFFFF_FFEC,  32'd10,         32'd1,          1'b0);
        step("slt_10_m20",  ALU_SLT,    32'd10,         32'hFFFF_FFEC,  32'd0,          1'b1);
        step("sltu_3_5",    ALU_SLTU,   32'd3,          32'd5,          32'd1,          1'b0);
        step("sltu_5_3",    ALU_SLTU,   32'd5,          32'd3,          32'd0,          1'b1);
        step("sltu_max_1",  ALU_SLTU,   32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1);
        step("reserved_15", alu_sel_e'(4'd15), 32'd7,   32'd9,          32'd0,          1'b1);

`ifdef ALU_MUL_EN
        step("mul_3_4",     ALU_MUL,    32'd3,          32'd4,          32'd12,         1'b0);
        step("mulh_min",    ALU_MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  1'b0);
        step("mulhu_max",   ALU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b0);
        step("mulhsu_m1_2", ALU_MULHSU, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  1'b0);
`else
        step("mul_3_4",     ALU_MUL,    32'd3,          32'd4,          32'd0,          1'b1);
        step("mulhu_off",   ALU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          1'b1);
`endif

        // A reset asserted on the same edge as an operation discards that operation.
        @(negedge clk);
        rst = 1'b1;
        sel = ALU_ADD;
        op1 = 32'd5;
        op2 = 32'd10;
        @(posedge clk);
        #1;
        check("rst_mid", 32'd0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_release", 32'd15, 1'b0);
        step("after_rst", ALU_XOR, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
